// File: rtl/seq_alu.sv
// seq_alu: sequential 16-bit ALU behind the control unit's DECODE/WAIT states.
// A request is accepted in IDLE when bgn is high. Single-cycle ops complete at the
// acceptance edge. MUL/DIV/MOD iterate for WIDTH cycles in BUSY. Results are then
// held in DONE until the requester drops bgn (4-phase handshake).
// Optional build macro: FAST_MUL_EN makes MUL a single-cycle combinational multiply.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bgn                       request, held until rdy is seen
//   opcode[5:0]               operation = opcode[5:1], opcode[0] ignored
//   A, B                      operands
//   acc1, acc2                primary / secondary result
//   zero, negative, carry, overflow   registered flags
//   rdy                       results valid (DONE)
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bgn,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] acc1,
  output logic [WIDTH-1:0] acc2,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             rdy
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_LSR = 5'b00011;
  localparam logic [4:0] OP_LSL = 5'b00100;
  localparam logic [4:0] OP_RSR = 5'b00101;
  localparam logic [4:0] OP_RSL = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b00111;
  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam logic [4:0] OP_MOD = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_XOR = 5'b01100;
  localparam logic [4:0] OP_NOT = 5'b01101;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_TST = 5'b01111;
  localparam logic [4:0] OP_INC = 5'b10000;
  localparam logic [4:0] OP_DEC = 5'b10001;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_nxt;

  logic [4:0]       op_in_c;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_hi;     // MUL: product high half; DIV/MOD: partial remainder
  logic [WIDTH-1:0] work_lo;     // MUL: multiplier/product low half; DIV/MOD: quotient
  logic [CW-1:0]    cnt;

  logic unused_opcode_lsb;
  assign unused_opcode_lsb = opcode[0];
  assign op_in_c = opcode[5:1];

  // Requests that must take the BUSY path (divide by zero short-circuits)
  logic div_op_c, mul_iter_c, iter_go_c, last_c;
  assign div_op_c = (op_in_c == OP_DIV) || (op_in_c == OP_MOD);
`ifdef FAST_MUL_EN
  assign mul_iter_c = 1'b0;
`else
  assign mul_iter_c = (op_in_c == OP_MUL);
`endif
  assign iter_go_c = mul_iter_c || (div_op_c && (|B));
  assign last_c    = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bgn) state_nxt = iter_go_c ? S_BUSY : S_DONE;
      S_BUSY:  if (last_c) state_nxt = S_DONE;
      S_DONE:  if (!bgn) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Arithmetic building blocks for single-cycle ops (driven from the request ports)
  logic [W1-1:0]    add_c, sub_c, inc_c, dec_c, lsr_c, lsl_c;
  logic [WIDTH-1:0] ror_c, rol_c;
  logic [SHW-1:0]   amt_c;
  assign amt_c = B[SHW-1:0];
  assign add_c = {1'b0, A} + {1'b0, B};
  assign sub_c = {1'b0, A} - {1'b0, B};
  assign inc_c = {1'b0, A} + W1'(1);
  assign dec_c = {1'b0, A} - W1'(1);
  assign lsr_c = {A, 1'b0} >> amt_c;          // bit 0 is the last bit shifted out
  assign lsl_c = {1'b0, A} << amt_c;          // top bit is the last bit shifted out
  assign ror_c = WIDTH'({A, A} >> amt_c);
  assign rol_c = WIDTH'(({A, A} << amt_c) >> WIDTH);

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_c;
  assign prod_c = {WIDTH'(0), A} * {WIDTH'(0), B};
`endif

  // Single-cycle result selection
  logic [WIDTH-1:0] sc_acc1_c, sc_acc2_c, sc_res_c;
  logic             sc_c_c, sc_v_c, sc_upd_c;
  always_comb begin
    sc_acc1_c = A;
    sc_acc2_c = '0;
    sc_res_c  = '0;
    sc_c_c    = 1'b0;
    sc_v_c    = 1'b0;
    sc_upd_c  = 1'b1;
    case (op_in_c)
      OP_ADD: begin
        sc_acc1_c = add_c[WIDTH-1:0];
        sc_c_c    = add_c[WIDTH];
        sc_v_c    = (A[WIDTH-1] == B[WIDTH-1]) && (add_c[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_acc1_c = sub_c[WIDTH-1:0];
        sc_c_c    = sub_c[WIDTH];
        sc_v_c    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_c[WIDTH-1] != A[WIDTH-1]);
      end
      OP_LSR: begin
        sc_acc1_c = lsr_c[WIDTH:1];
        sc_c_c    = lsr_c[0];
      end
      OP_LSL: begin
        sc_acc1_c = lsl_c[WIDTH-1:0];
        sc_c_c    = lsl_c[WIDTH];
      end
      OP_RSR: sc_acc1_c = ror_c;
      OP_RSL: sc_acc1_c = rol_c;
`ifdef FAST_MUL_EN
      OP_MUL: begin
        sc_acc1_c = prod_c[WIDTH-1:0];
        sc_acc2_c = prod_c[2*WIDTH-1:WIDTH];
        sc_c_c    = |prod_c[2*WIDTH-1:WIDTH];
        sc_v_c    = |prod_c[2*WIDTH-1:WIDTH];
      end
`endif
      // Only reached with B == 0: divide by zero
      OP_DIV: begin
        sc_acc1_c = '1;
        sc_acc2_c = A;
        sc_v_c    = 1'b1;
      end
      OP_MOD: begin
        sc_acc1_c = A;
        sc_acc2_c = '1;
        sc_v_c    = 1'b1;
      end
      OP_AND: sc_acc1_c = A & B;
      OP_OR:  sc_acc1_c = A | B;
      OP_XOR: sc_acc1_c = A ^ B;
      OP_NOT: sc_acc1_c = ~A;
      OP_CMP: begin
        sc_c_c = sub_c[WIDTH];
        sc_v_c = (A[WIDTH-1] != B[WIDTH-1]) && (sub_c[WIDTH-1] != A[WIDTH-1]);
      end
      OP_TST: ;
      OP_INC: begin
        sc_acc1_c = inc_c[WIDTH-1:0];
        sc_c_c    = inc_c[WIDTH];
        sc_v_c    = !A[WIDTH-1] && inc_c[WIDTH-1];
      end
      OP_DEC: begin
        sc_acc1_c = dec_c[WIDTH-1:0];
        sc_c_c    = dec_c[WIDTH];
        sc_v_c    = A[WIDTH-1] && !dec_c[WIDTH-1];
      end
      default: sc_upd_c = 1'b0;
    endcase
    // Flag source is the result except for CMP (difference) and TST (A & B)
    if (op_in_c == OP_CMP)      sc_res_c = sub_c[WIDTH-1:0];
    else if (op_in_c == OP_TST) sc_res_c = A & B;
    else                        sc_res_c = sc_acc1_c;
  end

  // One shift-add multiply step: add multiplicand when LSB set, shift right
  logic [W1-1:0]    mul_sum_c;
  logic [WIDTH-1:0] mul_hi_c, mul_lo_c;
  assign mul_sum_c = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_q} : W1'(0));
  assign mul_hi_c  = mul_sum_c[WIDTH:1];
  assign mul_lo_c  = {mul_sum_c[0], work_lo[WIDTH-1:1]};

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  logic [W1-1:0]    div_rs_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_hi_c, div_lo_c;
  assign div_rs_c = {work_hi, work_lo[WIDTH-1]};
  assign div_ge_c = (div_rs_c >= {1'b0, b_q});
  assign div_hi_c = div_ge_c ? WIDTH'(div_rs_c - {1'b0, b_q}) : div_rs_c[WIDTH-1:0];
  assign div_lo_c = {work_lo[WIDTH-2:0], div_ge_c};

  logic             op_q_mul_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;
  assign op_q_mul_c = (op_q == OP_MUL);
  assign step_hi_c  = op_q_mul_c ? mul_hi_c : div_hi_c;
  assign step_lo_c  = op_q_mul_c ? mul_lo_c : div_lo_c;

  // Final iterative results, valid on the last BUSY cycle
  logic [WIDTH-1:0] it_acc1_c, it_acc2_c;
  logic             it_cv_c;
  always_comb begin
    it_acc1_c = step_lo_c;
    it_acc2_c = step_hi_c;
    it_cv_c   = 1'b0;
    if (op_q_mul_c) begin
      it_cv_c = |step_hi_c;
    end else if (op_q == OP_MOD) begin
      it_acc1_c = step_hi_c;
      it_acc2_c = step_lo_c;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      b_q      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      cnt      <= '0;
      acc1     <= '0;
      acc2     <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      rdy <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (bgn) begin
            op_q    <= op_in_c;
            b_q     <= B;
            work_hi <= '0;
            work_lo <= A;
            cnt     <= '0;
            if (!iter_go_c) begin
              acc1 <= sc_acc1_c;
              acc2 <= sc_acc2_c;
              if (sc_upd_c) begin
                zero     <= (sc_res_c == '0);
                negative <= sc_res_c[WIDTH-1];
                carry    <= sc_c_c;
                overflow <= sc_v_c;
              end
            end
          end
        end
        S_BUSY: begin
          work_hi <= step_hi_c;
          work_lo <= step_lo_c;
          cnt     <= cnt + CW'(1);
          if (last_c) begin
            acc1     <= it_acc1_c;
            acc2     <= it_acc2_c;
            zero     <= (it_acc1_c == '0);
            negative <= it_acc1_c[WIDTH-1];
            carry    <= it_cv_c;
            overflow <= it_cv_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Datapath ALU directly downstream of the control unit's DECODE/WAIT states. It accepts a request (`bgn`) carrying the opcode and two 16-bit operands, and executes it. Single-cycle ops finish in 1 cycle. MUL/DIV/MOD run iteratively. It returns `acc1`/`acc2`, four registered flags and `rdy` under a 4-phase handshake.

Parameters:
WIDTH, 16, operand/result width; the control unit requires 16.
SHW, 4, shift-amount width; shifts/rotates use B[SHW-1:0].

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
bgn  input  1  request; held high by requester until it sees rdy
opcode  input  6  instruction opcode; operation = opcode[5:1], opcode[0] ignored
A  input  WIDTH  operand A (destination register value)
B  input  WIDTH  operand B (immediate or register)
acc1  output  WIDTH  primary result
acc2  output  WIDTH  secondary result (MUL high half, DIV remainder, MOD quotient)
zero  output  1  flag
negative  output  1  flag
carry  output  1  flag
overflow  output  1  flag
rdy  output  1  operation complete, results valid

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - acc1, acc2, all flags, rdy = 0.
  - Iteration counter and internal operand registers cleared.
  - Reset asserted mid-operation aborts the operation; nothing completes.
- States: IDLE, BUSY, DONE.
- IDLE, bgn=1 at an edge:
  - Latch opcode, A and B.
  - Single-cycle op: results and flags are registered at that same edge and the block goes to DONE. rdy=1 at the next cycle (latency 1).
  - MUL/DIV/MOD: go to BUSY with counter=0.
- BUSY:
  - One iteration per cycle for 16 cycles.
  - At counter=15, results and flags are written and the block goes to DONE. rdy rises 17 cycles after acceptance.
  - The operation completes even if bgn drops in BUSY.
- DONE:
  - rdy=1 while bgn=1; no re-execution.
  - bgn=0 → IDLE, rdy=0 on the next cycle.
- acc1, acc2 and flags hold their values until the next completion.
- Ops (opcode[5:1]):
  - ADD 00001: A+B.
  - SUB 00010: A-B.
  - LSR 00011: logical right shift. LSL 00100: logical left shift.
  - RSR 00101: rotate right. RSL 00110: rotate left.
  - MUL 00111: unsigned 32-bit product; acc1 = low half, acc2 = high half.
  - DIV 01000: unsigned restoring division; acc1 = quotient, acc2 = remainder.
  - MOD 01001: unsigned restoring division; acc1 = remainder, acc2 = quotient.
  - AND 01010, OR 01011, XOR 01100: bitwise.
  - NOT 01101: ~A.
  - CMP 01110: flags from A-B, acc1 = A (unchanged).
  - TST 01111: flags from A&B, acc1 = A.
  - INC 10000: A+1. DEC 10001: A-1.
  - Any other code (incl. NOP 11111): acc1 = A, acc2 = 0, flags unchanged, 1-cycle latency.
- acc2 = 0 for every op except MUL/DIV/MOD.
- Flags:
  - zero = (result==0); negative = result[15], where result is the flag source (difference for CMP, A&B for TST).
  - ADD/INC: carry = carry-out of bit 15.
  - SUB/CMP/DEC: carry = borrow (A<B unsigned).
  - ADD/SUB/CMP/INC/DEC: overflow = signed two's-complement overflow.
  - Shifts: carry = last bit shifted out (0 when shift amount is 0); overflow = 0.
  - Rotates and logic ops: carry = 0, overflow = 0.
  - MUL: carry = overflow = (acc2≠0).
  - DIV/MOD: carry = 0, overflow = 0.
- Divide by zero (B=0, DIV/MOD):
  - Completes in 1 cycle.
  - quotient = 16'hFFFF, remainder = A.
  - overflow = 1.

Optional Feature:
FAST_MUL_EN
- Defined: MUL uses a combinational 16x16 multiplier and completes in 1 cycle, the same as single-cycle ops.
- Undefined: 16-cycle shift-add multiplier as described under Behaviour.
- DIV/MOD are iterative in both cases.

Test Plan:
- ADD A=7FFF, B=0001, bgn held → acc1=8000, negative=1, overflow=1, carry=0, zero=0; rdy high 1 cycle after acceptance.
- SUB A=0003, B=0005 → acc1=FFFE, carry=1, negative=1. Then CMP A=0005, B=0005 → acc1=0005, zero=1, carry=0.
- MUL A=1234, B=0100 → acc1=3400, acc2=0012, carry=overflow=1.
  - rdy 17 cycles after acceptance, or 1 cycle with FAST_MUL_EN.
  - A=FFFF, B=FFFF → acc1=0001, acc2=FFFE.
- DIV A=0064, B=0007 → acc1=000E, acc2=0002. MOD same operands → acc1=0002, acc2=000E. DIV A=1234, B=0 → acc1=FFFF, acc2=1234, overflow=1 after 1 cycle.
- LSL A=8001, B=0001 → acc1=0002, carry=1. RSR A=0001, B=0004 → acc1=1000, carry=0.
- Start MUL, assert rst at the 5th BUSY cycle → next cycle: all outputs 0, rdy=0, IDLE. Then ADD 0002+0003 → acc1=0005.
  - Separately, keep bgn high 5 cycles after rdy → rdy stays 1, outputs unchanged, no second execution.
